// File: rtl/ifetch_queue.sv
// Instruction fetch front end: PC generation, ROM request issue, and a DEPTH-entry {addr, inst} queue toward decode.
// Latency: a request in cycle N returns data in N+1, and that instruction is visible at the queue head in N+2.
// Backpressure: requests are credit-limited (count - pop + inflight < DEPTH), so a returning response always finds a free slot.
module ifetch_queue #(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       rom_req_o,
  output logic [ADDR_W-1:0]          rom_addr_o,
  input  logic [INST_W-1:0]          rom_inst_i,
  input  logic                       redirect_i,
  input  logic [ADDR_W-1:0]          redirect_pc_i,
  output logic                       inst_valid_o,
  output logic [INST_W-1:0]          inst_o,
  output logic [ADDR_W-1:0]          inst_addr_o,
  input  logic                       inst_ready_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] fetch_pc;
  logic              inflight;
  logic [ADDR_W-1:0] inflight_addr;
  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [INST_W-1:0] mem_inst [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [CW-1:0]     count;

  logic              pop;
  logic              push;
  logic [CW:0]       credit_used;
  logic              credit_ok;
  logic [ADDR_W-1:0] redirect_pc_aligned;

  // Handshake, credit check and head read; reset and redirect mask both valid and issue.
  always_comb begin
    inst_valid_o        = (count != '0) & ~redirect_i & ~rst;
    pop                 = inst_valid_o & inst_ready_i;
    push                = inflight & ~redirect_i & ~rst;
    // Occupancy after this cycle's pop plus the response still on its way back.
    credit_used         = {1'b0, count} - {{CW{1'b0}}, pop} + {{CW{1'b0}}, inflight};
    credit_ok           = credit_used < (CW+1)'(DEPTH);
    rom_req_o           = ~rst & ~redirect_i & credit_ok;
    rom_addr_o          = fetch_pc;
    inst_o              = mem_inst[rd_ptr];
    inst_addr_o         = mem_addr[rd_ptr];
    count_o             = count;
    // Low two bits of the target are ignored; fetch is always word aligned.
    redirect_pc_aligned = redirect_pc_i & ~ADDR_W'(3);
  end

  // Control state: reset beats redirect, which beats issue/push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc      <= RESET_PC;
      inflight      <= 1'b0;
      inflight_addr <= '0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
    end else if (redirect_i) begin
      fetch_pc <= redirect_pc_aligned;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      inflight <= rom_req_o;
      if (rom_req_o) begin
        fetch_pc      <= fetch_pc + ADDR_W'(4);
        inflight_addr <= fetch_pc;
      end
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Queue storage; entries are only meaningful below count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr] <= inflight_addr;
      mem_inst[wr_ptr] <= rom_inst_i;
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
module tb_ifetch_queue;

  localparam logic [31:0] SIG = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        rom_req_o;
  logic [31:0] rom_addr_o;
  logic [31:0] rom_inst_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        inst_ready_i;
  logic [2:0]  count_o;

  int total = 0;
  int bad   = 0;

  ifetch_queue #(.ADDR_W(32), .INST_W(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk           (clk),
    .rst           (rst),
    .rom_req_o     (rom_req_o),
    .rom_addr_o    (rom_addr_o),
    .rom_inst_i    (rom_inst_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .inst_valid_o  (inst_valid_o),
    .inst_o        (inst_o),
    .inst_addr_o   (inst_addr_o),
    .inst_ready_i  (inst_ready_i),
    .count_o       (count_o)
  );

  always #5 clk = ~clk;

  // One-cycle ROM: data for an accepted request is presented in the following cycle.
  always @(posedge clk) begin
    if (rom_req_o) rom_inst_i <= rom_addr_o ^ SIG;
    else           rom_inst_i <= 32'hDEAD_BEEF;
  end

  typedef struct {
    logic        rst;
    logic        ready;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_iaddr;
    logic [2:0]  exp_count;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic rd, input logic [31:0] rpc, input logic rdy);
    @(posedge clk);
    #1;
    rst           = r;
    redirect_i    = rd;
    redirect_pc_i = rpc;
    inst_ready_i  = rdy;
    @(negedge clk);
  endtask

  task automatic chk_out(input string tag, input logic req, input logic [31:0] addr,
                         input logic vld, input logic [31:0] iaddr, input logic [2:0] cnt);
    chk({tag, ".req"}, {31'b0, rom_req_o}, {31'b0, req});
    if (req) chk({tag, ".addr"}, rom_addr_o, addr);
    chk({tag, ".valid"}, {31'b0, inst_valid_o}, {31'b0, vld});
    if (vld) begin
      chk({tag, ".iaddr"}, inst_addr_o, iaddr);
      chk({tag, ".inst"}, inst_o, iaddr ^ SIG);
    end
    chk({tag, ".count"}, {29'b0, count_o}, {29'b0, cnt});
  endtask

  initial begin
    logic [31:0] seen[$];
    logic [31:0] wrap_exp[4];
    int          budget;

    rst = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0; inst_ready_i = 1'b0;
    repeat (2) @(posedge clk);

    // Reset, first fetches, fill to saturation with ready low, then drain.
    //           rst   rdy   req   addr   vld   iaddr  cnt
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  3'd0};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 32'h0,  1'b0, 32'h0,  3'd0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 32'h4,  1'b0, 32'h0,  3'd0};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 32'h8,  1'b1, 32'h0,  3'd1};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 32'hC,  1'b1, 32'h0,  3'd2};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 32'h0,  3'd3};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 32'h0,  3'd4};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 32'h0,  3'd4};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 32'h10, 1'b1, 32'h0,  3'd4};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 32'h14, 1'b1, 32'h4,  3'd3};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 32'h18, 1'b1, 32'h8,  3'd3};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 32'h1C, 1'b1, 32'hC,  3'd3};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 32'h20, 1'b1, 32'h10, 3'd3};

    for (int i = 0; i < 13; i++) begin
      step(vecs[i].rst, 1'b0, 32'h0, vecs[i].ready);
      chk_out($sformatf("vec%0d", i), vecs[i].exp_req, vecs[i].exp_addr,
              vecs[i].exp_valid, vecs[i].exp_iaddr, vecs[i].exp_count);
    end

    // Redirect with count=2, one response in flight, and ready high.
    step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    chk_out("pre_redir", 1'b1, 32'h8, 1'b1, 32'h0, 3'd1);
    step(1'b0, 1'b1, 32'h0000_0103, 1'b1);
    chk_out("redir_R", 1'b0, 32'h0, 1'b0, 32'h0, 3'd2);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk_out("redir_R1", 1'b1, 32'h100, 1'b0, 32'h0, 3'd0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk_out("redir_R2", 1'b1, 32'h104, 1'b0, 32'h0, 3'd0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk_out("redir_R3", 1'b1, 32'h108, 1'b1, 32'h100, 3'd1);

    // Address wrap across the top of the address space.
    wrap_exp[0] = 32'hFFFF_FFF8; wrap_exp[1] = 32'hFFFF_FFFC;
    wrap_exp[2] = 32'h0000_0000; wrap_exp[3] = 32'h0000_0004;
    step(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1);
    budget = 12;
    while (seen.size() < 4 && budget > 0) begin
      step(1'b0, 1'b0, 32'h0, 1'b1);
      if (inst_valid_o) seen.push_back(inst_addr_o);
      budget--;
    end
    if (seen.size() < 4) begin
      total++; bad++;
      $display("FAIL wrap_timeout: got %0d outputs expected 4", seen.size());
    end else begin
      for (int i = 0; i < 4; i++) chk($sformatf("wrap%0d", i), seen[i], wrap_exp[i]);
    end

    // Reset pulse while full and stalled.
    repeat (8) step(1'b0, 1'b0, 32'h0, 1'b0);
    chk_out("full_stall", 1'b0, 32'h0, 1'b1, 32'h8, 3'd4);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    chk({"rstpulse", ".valid"}, {31'b0, inst_valid_o}, 32'h0);
    chk({"rstpulse", ".req"}, {31'b0, rom_req_o}, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk_out("post_rst0", 1'b1, 32'h0, 1'b0, 32'h0, 3'd0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk_out("post_rst1", 1'b1, 32'h4, 1'b0, 32'h0, 3'd0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk_out("post_rst2", 1'b1, 32'h8, 1'b1, 32'h0, 3'd1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk_out("post_rst3", 1'b1, 32'hC, 1'b1, 32'h4, 3'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
